// File: rtl/id_ex_fwd_stage_if.sv
// Signal bundle between decode, the forwarding sources and the ID/EX register.
// The master side drives decode, forwarding and control inputs; the slave is the stage itself.
interface id_ex_fwd_stage_if #(
    parameter int DATA_WIDTH = 16,
    parameter int SEL_BITS   = 3,
    parameter int CNT_WIDTH  = 16
);
    logic                  id_valid;
    logic [SEL_BITS-1:0]   id_rs_sel;
    logic [SEL_BITS-1:0]   id_rt_sel;
    logic                  id_rs_used;
    logic                  id_rt_used;
    logic [SEL_BITS-1:0]   id_rd_sel;
    logic                  id_rd_we;
    logic                  id_is_load;
    logic [DATA_WIDTH-1:0] id_imm;
    logic [DATA_WIDTH-1:0] rf_rs_data;
    logic [DATA_WIDTH-1:0] rf_rt_data;
    logic [DATA_WIDTH-1:0] ex_result;
    logic                  mem_valid;
    logic                  mem_rd_we;
    logic [SEL_BITS-1:0]   mem_rd_sel;
    logic [DATA_WIDTH-1:0] mem_data;
    logic                  wb_we;
    logic [SEL_BITS-1:0]   wb_rd_sel;
    logic [DATA_WIDTH-1:0] wb_data;
    logic                  stall_in;
    logic                  flush;
    logic                  stall_out;
    logic                  ex_valid;
    logic [DATA_WIDTH-1:0] ex_rs_data;
    logic [DATA_WIDTH-1:0] ex_rt_data;
    logic [DATA_WIDTH-1:0] ex_imm;
    logic [SEL_BITS-1:0]   ex_rd_sel;
    logic                  ex_rd_we;
    logic                  ex_is_load;
    logic [CNT_WIDTH-1:0]  bubble_cnt;

    modport master (
        output id_valid, id_rs_sel, id_rt_sel, id_rs_used, id_rt_used, id_rd_sel,
               id_rd_we, id_is_load, id_imm, rf_rs_data, rf_rt_data, ex_result,
               mem_valid, mem_rd_we, mem_rd_sel, mem_data, wb_we, wb_rd_sel, wb_data,
               stall_in, flush,
        input  stall_out, ex_valid, ex_rs_data, ex_rt_data, ex_imm, ex_rd_sel,
               ex_rd_we, ex_is_load, bubble_cnt
    );

    modport slave (
        input  id_valid, id_rs_sel, id_rt_sel, id_rs_used, id_rt_used, id_rd_sel,
               id_rd_we, id_is_load, id_imm, rf_rs_data, rf_rt_data, ex_result,
               mem_valid, mem_rd_we, mem_rd_sel, mem_data, wb_we, wb_rd_sel, wb_data,
               stall_in, flush,
        output stall_out, ex_valid, ex_rs_data, ex_rt_data, ex_imm, ex_rd_sel,
               ex_rd_we, ex_is_load, bubble_cnt
    );
endinterface

// File: rtl/id_ex_fwd_stage.sv
// ID/EX boundary: EX/MEM/WB operand forwarding, load-use bubble insertion,
// the ID/EX pipeline register and a saturating bubble counter.
module id_ex_fwd_stage #(
    parameter int DATA_WIDTH = 16,
    parameter int SEL_BITS   = 3,
    parameter int CNT_WIDTH  = 16
) (
    input  logic               clk,
    input  logic               rst,
    id_ex_fwd_stage_if.slave   bus
);
    logic                  ex_valid_q;
    logic [DATA_WIDTH-1:0] ex_rs_q;
    logic [DATA_WIDTH-1:0] ex_rt_q;
    logic [DATA_WIDTH-1:0] ex_imm_q;
    logic [SEL_BITS-1:0]   ex_rd_sel_q;
    logic                  ex_rd_we_q;
    logic                  ex_is_load_q;
    logic [CNT_WIDTH-1:0]  bubble_cnt_q;

    logic [DATA_WIDTH-1:0] rs_fwd;
    logic [DATA_WIDTH-1:0] rt_fwd;
    logic                  ex_can_fwd;
    logic                  mem_can_fwd;
    logic                  load_use;

    // A load in EX has no data yet, so it never forwards; load_use covers that case.
    assign ex_can_fwd  = ex_valid_q & ex_rd_we_q & ~ex_is_load_q;
    assign mem_can_fwd = bus.mem_valid & bus.mem_rd_we;

    always_comb begin
        rs_fwd = bus.rf_rs_data;
        if (ex_can_fwd && ex_rd_sel_q == bus.id_rs_sel)
            rs_fwd = bus.ex_result;
        else if (mem_can_fwd && bus.mem_rd_sel == bus.id_rs_sel)
            rs_fwd = bus.mem_data;
        else if (bus.wb_we && bus.wb_rd_sel == bus.id_rs_sel)
            rs_fwd = bus.wb_data;
    end

    always_comb begin
        rt_fwd = bus.rf_rt_data;
        if (ex_can_fwd && ex_rd_sel_q == bus.id_rt_sel)
            rt_fwd = bus.ex_result;
        else if (mem_can_fwd && bus.mem_rd_sel == bus.id_rt_sel)
            rt_fwd = bus.mem_data;
        else if (bus.wb_we && bus.wb_rd_sel == bus.id_rt_sel)
            rt_fwd = bus.wb_data;
    end

    assign load_use = bus.id_valid & ex_valid_q & ex_is_load_q & ex_rd_we_q &
                      ((bus.id_rs_used & (ex_rd_sel_q == bus.id_rs_sel)) |
                       (bus.id_rt_used & (ex_rd_sel_q == bus.id_rt_sel)));

    assign bus.stall_out = bus.stall_in | (load_use & ~bus.flush);

    // Flush outranks the downstream stall so a redirect can never be held off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_q   <= 1'b0;
            ex_rs_q      <= '0;
            ex_rt_q      <= '0;
            ex_imm_q     <= '0;
            ex_rd_sel_q  <= '0;
            ex_rd_we_q   <= 1'b0;
            ex_is_load_q <= 1'b0;
            bubble_cnt_q <= '0;
        end else if (bus.flush || (!bus.stall_in && load_use)) begin
            ex_valid_q   <= 1'b0;
            ex_rs_q      <= '0;
            ex_rt_q      <= '0;
            ex_imm_q     <= '0;
            ex_rd_sel_q  <= '0;
            ex_rd_we_q   <= 1'b0;
            ex_is_load_q <= 1'b0;
            if (!bus.flush && bubble_cnt_q != '1)
                bubble_cnt_q <= bubble_cnt_q + 1'b1;
        end else if (!bus.stall_in) begin
            ex_valid_q   <= bus.id_valid;
            ex_rs_q      <= rs_fwd;
            ex_rt_q      <= rt_fwd;
            ex_imm_q     <= bus.id_imm;
            ex_rd_sel_q  <= bus.id_rd_sel;
            ex_rd_we_q   <= bus.id_rd_we & bus.id_valid;
            ex_is_load_q <= bus.id_is_load & bus.id_valid;
        end
    end

    assign bus.ex_valid   = ex_valid_q;
    assign bus.ex_rs_data = ex_rs_q;
    assign bus.ex_rt_data = ex_rt_q;
    assign bus.ex_imm     = ex_imm_q;
    assign bus.ex_rd_sel  = ex_rd_sel_q;
    assign bus.ex_rd_we   = ex_rd_we_q;
    assign bus.ex_is_load = ex_is_load_q;
    assign bus.bubble_cnt = bubble_cnt_q;
endmodule

// File: tb/tb_id_ex_fwd_stage.sv
// Bench for id_ex_fwd_stage: directed scenarios plus random traffic, all checked
// against a behavioural model of the ID/EX contents and the bubble count.
module tb_id_ex_fwd_stage;
    localparam int DW = 16;
    localparam int SB = 3;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    id_ex_fwd_stage_if #(.DATA_WIDTH(DW), .SEL_BITS(SB), .CNT_WIDTH(CW)) bus ();

    id_ex_fwd_stage #(.DATA_WIDTH(DW), .SEL_BITS(SB), .CNT_WIDTH(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    logic          m_valid, m_we, m_load;
    logic [DW-1:0] m_rs, m_rt, m_imm;
    logic [SB-1:0] m_rd;
    int            m_cnt;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic modelReset();
        m_valid = 0; m_we = 0; m_load = 0;
        m_rs = '0; m_rt = '0; m_imm = '0; m_rd = '0; m_cnt = 0;
    endtask

    // Producers are applied oldest first so the youngest matching one ends up winning.
    function automatic logic [DW-1:0] pickOperand(input logic [SB-1:0] sel, input logic [DW-1:0] rf);
        logic [DW-1:0] v = rf;
        if (bus.wb_we && bus.wb_rd_sel == sel) v = bus.wb_data;
        if (bus.mem_valid && bus.mem_rd_we && bus.mem_rd_sel == sel) v = bus.mem_data;
        if (m_valid && m_we && !m_load && m_rd == sel) v = bus.ex_result;
        return v;
    endfunction

    function automatic logic modelLoadUse();
        logic reads_rs = bus.id_rs_used && bus.id_rs_sel == m_rd;
        logic reads_rt = bus.id_rt_used && bus.id_rt_sel == m_rd;
        return bus.id_valid && m_valid && m_load && m_we && (reads_rs || reads_rt);
    endfunction

    task automatic clearInputs();
        bus.id_valid = 0; bus.id_rs_sel = 0; bus.id_rt_sel = 0; bus.id_rs_used = 0;
        bus.id_rt_used = 0; bus.id_rd_sel = 0; bus.id_rd_we = 0; bus.id_is_load = 0;
        bus.id_imm = 0; bus.rf_rs_data = 0; bus.rf_rt_data = 0; bus.ex_result = 0;
        bus.mem_valid = 0; bus.mem_rd_we = 0; bus.mem_rd_sel = 0; bus.mem_data = 0;
        bus.wb_we = 0; bus.wb_rd_sel = 0; bus.wb_data = 0; bus.stall_in = 0; bus.flush = 0;
    endtask

    task automatic applyStimulus();
        bus.id_valid   = ($urandom_range(0, 7) != 0);
        bus.id_rs_sel  = SB'($urandom_range(0, 3));
        bus.id_rt_sel  = SB'($urandom_range(0, 3));
        bus.id_rs_used = $urandom_range(0, 1);
        bus.id_rt_used = $urandom_range(0, 1);
        bus.id_rd_sel  = SB'($urandom_range(0, 3));
        bus.id_rd_we   = $urandom_range(0, 1);
        bus.id_is_load = ($urandom_range(0, 2) == 0);
        bus.id_imm     = DW'($urandom);
        bus.rf_rs_data = DW'($urandom);
        bus.rf_rt_data = DW'($urandom);
        bus.ex_result  = DW'($urandom);
        bus.mem_valid  = $urandom_range(0, 1);
        bus.mem_rd_we  = $urandom_range(0, 1);
        bus.mem_rd_sel = SB'($urandom_range(0, 3));
        bus.mem_data   = DW'($urandom);
        bus.wb_we      = $urandom_range(0, 1);
        bus.wb_rd_sel  = SB'($urandom_range(0, 3));
        bus.wb_data    = DW'($urandom);
        bus.stall_in   = ($urandom_range(0, 7) == 0);
        bus.flush      = ($urandom_range(0, 7) == 0);
    endtask

    // Entered just after a rising edge with new inputs applied; leaves just after the next edge.
    task automatic stepAndCheck(input string tag);
        logic          lu, n_valid, n_we, n_load;
        logic [DW-1:0] n_rs, n_rt, n_imm;
        logic [SB-1:0] n_rd;
        int            n_cnt;
        #1;
        lu = modelLoadUse();
        checkOutput({tag, ".stall_out"}, 32'(bus.stall_out), 32'(bus.stall_in | (lu & ~bus.flush)));
        n_valid = m_valid; n_we = m_we; n_load = m_load;
        n_rs = m_rs; n_rt = m_rt; n_imm = m_imm; n_rd = m_rd; n_cnt = m_cnt;
        if (bus.flush || (!bus.stall_in && lu)) begin
            n_valid = 0; n_we = 0; n_load = 0; n_rs = 0; n_rt = 0; n_imm = 0; n_rd = 0;
            if (!bus.flush && m_cnt < (1 << CW) - 1) n_cnt = m_cnt + 1;
        end else if (!bus.stall_in) begin
            n_valid = bus.id_valid;
            n_rs    = pickOperand(bus.id_rs_sel, bus.rf_rs_data);
            n_rt    = pickOperand(bus.id_rt_sel, bus.rf_rt_data);
            n_imm   = bus.id_imm;
            n_rd    = bus.id_rd_sel;
            n_we    = bus.id_rd_we & bus.id_valid;
            n_load  = bus.id_is_load & bus.id_valid;
        end
        @(posedge clk);
        #1;
        m_valid = n_valid; m_we = n_we; m_load = n_load;
        m_rs = n_rs; m_rt = n_rt; m_imm = n_imm; m_rd = n_rd; m_cnt = n_cnt;
        checkOutput({tag, ".ex_valid"},   32'(bus.ex_valid),   32'(m_valid));
        checkOutput({tag, ".ex_rs_data"}, 32'(bus.ex_rs_data), 32'(m_rs));
        checkOutput({tag, ".ex_rt_data"}, 32'(bus.ex_rt_data), 32'(m_rt));
        checkOutput({tag, ".ex_imm"},     32'(bus.ex_imm),     32'(m_imm));
        checkOutput({tag, ".ex_rd_sel"},  32'(bus.ex_rd_sel),  32'(m_rd));
        checkOutput({tag, ".ex_rd_we"},   32'(bus.ex_rd_we),   32'(m_we));
        checkOutput({tag, ".ex_is_load"}, 32'(bus.ex_is_load), 32'(m_load));
        checkOutput({tag, ".bubble_cnt"}, 32'(bus.bubble_cnt), 32'(m_cnt));
    endtask

    task automatic decodeOp(input logic [SB-1:0] rs, input logic [SB-1:0] rt, input logic rs_used,
                            input logic rt_used, input logic [SB-1:0] rd, input logic load);
        bus.id_valid = 1; bus.id_rs_sel = rs; bus.id_rt_sel = rt; bus.id_rs_used = rs_used;
        bus.id_rt_used = rt_used; bus.id_rd_sel = rd; bus.id_rd_we = 1; bus.id_is_load = load;
    endtask

    initial begin
        clearInputs();
        modelReset();
        rst = 1;
        @(posedge clk);
        #1;
        checkOutput("reset.ex_valid",   32'(bus.ex_valid),   0);
        checkOutput("reset.bubble_cnt", 32'(bus.bubble_cnt), 0);
        checkOutput("reset.stall_out",  32'(bus.stall_out),  0);
        rst = 0;

        decodeOp(2, 3, 1, 1, 1, 0);
        bus.rf_rs_data = 16'h1111; bus.rf_rt_data = 16'h2222;
        stepAndCheck("basic");
        checkOutput("basic.rs_value", 32'(bus.ex_rs_data), 32'h1111);
        checkOutput("basic.rt_value", 32'(bus.ex_rt_data), 32'h2222);

        decodeOp(0, 0, 0, 0, 5, 0);
        stepAndCheck("prio.setup");
        decodeOp(5, 1, 1, 1, 6, 0);
        bus.ex_result = 16'hAAAA; bus.mem_valid = 1; bus.mem_rd_we = 1; bus.mem_rd_sel = 5;
        bus.mem_data = 16'hBBBB; bus.wb_we = 1; bus.wb_rd_sel = 5; bus.wb_data = 16'hCCCC;
        stepAndCheck("prio.ex");
        checkOutput("prio.ex_value", 32'(bus.ex_rs_data), 32'hAAAA);
        stepAndCheck("prio.mem");
        checkOutput("prio.mem_value", 32'(bus.ex_rs_data), 32'hBBBB);
        bus.mem_valid = 0;
        stepAndCheck("prio.wb");
        checkOutput("prio.wb_value", 32'(bus.ex_rs_data), 32'hCCCC);
        clearInputs();

        decodeOp(0, 0, 0, 0, 4, 1);
        stepAndCheck("lu.load");
        decodeOp(1, 4, 1, 1, 2, 0);
        #1 checkOutput("lu.stall_now", 32'(bus.stall_out), 1);
        stepAndCheck("lu.bubble");
        checkOutput("lu.bubble_valid", 32'(bus.ex_valid), 0);
        checkOutput("lu.bubble_cnt", 32'(bus.bubble_cnt), 1);
        bus.mem_valid = 1; bus.mem_rd_we = 1; bus.mem_rd_sel = 4; bus.mem_data = 16'h0F0F;
        stepAndCheck("lu.resume");
        checkOutput("lu.resume_rt", 32'(bus.ex_rt_data), 32'h0F0F);
        clearInputs();

        decodeOp(0, 0, 0, 0, 4, 1);
        stepAndCheck("flush.load");
        decodeOp(4, 4, 1, 1, 2, 0);
        bus.flush = 1;
        stepAndCheck("flush.lu");
        decodeOp(0, 0, 0, 0, 4, 1);
        bus.flush = 0;
        stepAndCheck("flush.load2");
        decodeOp(4, 4, 1, 1, 2, 0);
        bus.flush = 1; bus.stall_in = 1;
        stepAndCheck("flush.stall");
        checkOutput("flush.stall_cleared", 32'(bus.ex_valid), 0);
        clearInputs();

        decodeOp(0, 0, 0, 0, 3, 0);
        bus.id_imm = 16'h1234; bus.rf_rs_data = 16'h1234;
        stepAndCheck("hold.load");
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            bus.stall_in = 1; bus.flush = 0;
            stepAndCheck("hold");
            checkOutput("hold.imm", 32'(bus.ex_imm), 32'h1234);
        end
        clearInputs();

        for (int i = 0; i < (1 << CW) + 4; i++) begin
            decodeOp(0, 0, 0, 0, 4, 1);
            stepAndCheck("sat.load");
            decodeOp(4, 0, 1, 0, 4, 1);
            stepAndCheck("sat.bubble");
        end
        checkOutput("sat.max", 32'(bus.bubble_cnt), 32'((1 << CW) - 1));

        decodeOp(0, 0, 0, 0, 4, 1);
        stepAndCheck("rst.load");
        decodeOp(4, 4, 1, 1, 1, 0);
        #2 rst = 1;
        #1;
        modelReset();
        checkOutput("rst.bubble_cnt", 32'(bus.bubble_cnt), 0);
        checkOutput("rst.ex_valid",   32'(bus.ex_valid),   0);
        checkOutput("rst.stall_out",  32'(bus.stall_out),  0);
        @(posedge clk);
        #1 rst = 0;
        clearInputs();

        for (int i = 0; i < 400; i++) begin
            applyStimulus();
            stepAndCheck("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/id_ex_fwd_stage.md
Name: id_ex_fwd_stage

Overview:
- Decode/execute boundary stage. It sits directly downstream of the 8x16 register file and consumes its two read ports.
- Applies operand forwarding from the EX, MEM and WB stages onto the register-file read data.
- Detects load-use hazards and inserts one-cycle bubbles.
- Holds the ID/EX pipeline register with stall and flush control, plus a saturating bubble counter for performance debug.

Parameters:
- DATA_WIDTH, 16, operand, immediate and result width.
- SEL_BITS, 3, register select width (8 architectural registers).
- CNT_WIDTH, 16, bubble counter width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  decode holds a real instruction.
- id_rs_sel  in  SEL_BITS  source 1 register.
- id_rt_sel  in  SEL_BITS  source 2 register.
- id_rs_used  in  1  instruction reads rs.
- id_rt_used  in  1  instruction reads rt.
- id_rd_sel  in  SEL_BITS  destination register.
- id_rd_we  in  1  instruction writes rd.
- id_is_load  in  1  instruction is a load.
- id_imm  in  DATA_WIDTH  sign/zero-extended immediate.
- rf_rs_data  in  DATA_WIDTH  register-file read port 1 data.
- rf_rt_data  in  DATA_WIDTH  register-file read port 2 data.
- ex_result  in  DATA_WIDTH  combinational ALU result of the instruction in EX.
- mem_valid  in  1  MEM stage holds a valid instruction.
- mem_rd_we  in  1  MEM instruction writes rd.
- mem_rd_sel  in  SEL_BITS  MEM destination register.
- mem_data  in  DATA_WIDTH  MEM-stage result (load data or ALU result).
- wb_we  in  1  register-file write enable this cycle.
- wb_rd_sel  in  SEL_BITS  register-file write select.
- wb_data  in  DATA_WIDTH  register-file write data.
- stall_in  in  1  downstream stall; hold the ID/EX register.
- flush  in  1  kill the decode instruction (branch redirect).
- stall_out  out  1  hold PC and IF/ID this cycle.
- ex_valid  out  1  ID/EX register: valid.
- ex_rs_data  out  DATA_WIDTH  ID/EX register: forwarded rs operand.
- ex_rt_data  out  DATA_WIDTH  ID/EX register: forwarded rt operand.
- ex_imm  out  DATA_WIDTH  ID/EX register: immediate.
- ex_rd_sel  out  SEL_BITS  ID/EX register: destination register.
- ex_rd_we  out  1  ID/EX register: write enable.
- ex_is_load  out  1  ID/EX register: load flag.
- bubble_cnt  out  CNT_WIDTH  count of inserted bubbles.

Behaviour:
- Reset: all ex_* outputs and bubble_cnt clear to 0 immediately on rst, independent of clk. stall_out is combinational, so it is 0 while stall_in and flush are 0 and ex_valid is 0.
- Forwarding (combinational, per operand, shown for rs; rt is identical):
  - Priority 1, EX: if ex_valid & ex_rd_we & ~ex_is_load & ex_rd_sel==id_rs_sel, take ex_result.
  - Priority 2, MEM: else if mem_valid & mem_rd_we & mem_rd_sel==id_rs_sel, take mem_data.
  - Priority 3, WB: else if wb_we & wb_rd_sel==id_rs_sel, take wb_data. This covers the same-edge register-file write that the read port does not yet show.
  - Otherwise take rf_rs_data.
  - Register 0 is an ordinary register; there is no hardwired-zero exception.
- load_use = id_valid & ex_valid & ex_is_load & ex_rd_we & ((id_rs_used & ex_rd_sel==id_rs_sel) | (id_rt_used & ex_rd_sel==id_rt_sel)).
- stall_out = stall_in | (load_use & ~flush).
- ID/EX next-state, first matching rule wins:
  1. flush: load a bubble (ex_valid=0, ex_rd_we=0, ex_is_load=0; other fields 0), even if stall_in is high.
  2. stall_in: hold every field unchanged.
  3. load_use: load a bubble, increment bubble_cnt.
  4. Otherwise: capture id_valid, the forwarded operands, id_imm, id_rd_sel, and id_rd_we & id_valid, id_is_load & id_valid.
- A load-use stall lasts exactly one cycle. On the next cycle the load is in MEM and the dependent operand is forwarded from mem_data.
- id_valid=0 captures a bubble; this is not counted in bubble_cnt.
- bubble_cnt: increments only in rule 3 and saturates at all-ones.
- Reset asserted mid-stall: everything clears; no pending stall survives reset.

Test Plan:
- After reset release, id_valid=1, rs=2, rt=3, rf data 0x1111/0x2222, no hazards, one clock -> ex_valid=1, ex_rs_data=0x1111, ex_rt_data=0x2222, stall_out=0.
- Triple match on rs=5: EX ALU result 0xAAAA, MEM mem_data 0xBBBB, WB wb_data 0xCCCC -> EX wins, ex_rs_data=0xAAAA. Drop the EX match -> 0xBBBB. Drop MEM too -> 0xCCCC.
- Load to r4 in EX, decode uses rt=4 -> stall_out=1 for one cycle, ex_valid=0 next edge, bubble_cnt=1. Next cycle with mem_data=0x0F0F -> ex_rt_data=0x0F0F, stall_out=0.
- load_use and flush in the same cycle -> stall_out=0 (stall_in=0), bubble captured, bubble_cnt unchanged. With stall_in=1 and flush=1 -> ID/EX cleared, stall_out=1.
- stall_in held for 3 cycles with valid ID/EX contents 0x1234 -> all ex_* outputs unchanged across all 3 edges, bubble_cnt unchanged.
- Force 0xFFFF consecutive load-use bubbles, then one more -> bubble_cnt stays at 0xFFFF. Assert rst between edges -> bubble_cnt and ex_valid read 0 immediately.
